// File: rtl/user_obi_demux_wd.sv
// OBI subordinate demultiplexer with address decoder, built-in error sink and a
// per-target response watchdog that retires hung transactions and isolates the target.
module user_obi_demux_wd #(
    parameter int unsigned          AddrWidth     = 32,
    parameter int unsigned          DataWidth     = 32,
    parameter int unsigned          IdWidth       = 4,
    parameter int unsigned          NumPorts      = 4,
    parameter int unsigned          NumMaxTrans   = 2,
    parameter int unsigned          TimeoutCycles = 1024,
    parameter logic [DataWidth-1:0] ErrData       = 32'hBADCAB1E
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    // rule i occupies bits [i*2*AddrWidth +: 2*AddrWidth] as {start_addr, end_addr}
    input  logic [NumPorts*2*AddrWidth-1:0]   addr_map_i,
    input  logic [NumPorts-1:0]               port_en_i,
    input  logic                              hung_clear_i,
    // upstream request
    input  logic                              sbr_port_req_i,
    input  logic [AddrWidth-1:0]              sbr_port_addr_i,
    input  logic                              sbr_port_we_i,
    input  logic [DataWidth/8-1:0]            sbr_port_be_i,
    input  logic [DataWidth-1:0]              sbr_port_wdata_i,
    input  logic [IdWidth-1:0]                sbr_port_aid_i,
    // upstream response
    output logic                              sbr_port_gnt_o,
    output logic                              sbr_port_rvalid_o,
    output logic [DataWidth-1:0]              sbr_port_rdata_o,
    output logic                              sbr_port_err_o,
    output logic [IdWidth-1:0]                sbr_port_rid_o,
    // downstream requests: per-port req, shared a-channel payload
    output logic [NumPorts-1:0]               mgr_ports_req_o,
    output logic [AddrWidth-1:0]              mgr_ports_addr_o,
    output logic                              mgr_ports_we_o,
    output logic [DataWidth/8-1:0]            mgr_ports_be_o,
    output logic [DataWidth-1:0]              mgr_ports_wdata_o,
    output logic [IdWidth-1:0]                mgr_ports_aid_o,
    // downstream responses
    input  logic [NumPorts-1:0]               mgr_ports_gnt_i,
    input  logic [NumPorts-1:0]               mgr_ports_rvalid_i,
    input  logic [NumPorts*DataWidth-1:0]     mgr_ports_rdata_i,
    input  logic [NumPorts-1:0]               mgr_ports_err_i,
    input  logic [NumPorts*IdWidth-1:0]       mgr_ports_rid_i,
    output logic [NumPorts-1:0]               hung_o,
    output logic                              timeout_irq_o
);

    localparam int unsigned PortW = $clog2(NumPorts + 1);
    localparam int unsigned CntW  = $clog2(NumMaxTrans + 1);
    localparam int unsigned PtrW  = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
    localparam int unsigned WdW   = $clog2(TimeoutCycles);
    localparam int unsigned RuleW = 2 * AddrWidth;
    localparam logic [PortW-1:0] ErrIdx = PortW'(NumPorts);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FLUSH
    } state_e;

    state_e               state_q, state_d;
    logic [PortW-1:0]     tgt, cur_tgt_q;
    logic [CntW-1:0]      cnt_q;
    logic [IdWidth-1:0]   fifo_q [NumMaxTrans];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [WdW-1:0]       wd_q;
    logic [NumPorts-1:0]  hung_q;
    logic                 err_rsp_q, irq_q, clr_pend_q;

    logic                 found, tgt_gnt, issue_ok, hs, pop, tgt_rvalid, flush_entry;
    logic                 clr_req, clr_blocked;
    logic                 sel_rvalid, sel_err;
    logic [DataWidth-1:0] sel_rdata;
    logic [IdWidth-1:0]   sel_rid;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(NumMaxTrans - 1)) return '0;
        return p + PtrW'(1);
    endfunction

    // Lowest enabled, non-hung port whose rule covers the address wins.
    always_comb begin
        tgt   = ErrIdx;
        found = 1'b0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            if (!found && port_en_i[i] && !hung_q[i]
                && sbr_port_addr_i >= addr_map_i[i*RuleW+AddrWidth +: AddrWidth]
                && sbr_port_addr_i <  addr_map_i[i*RuleW +: AddrWidth]) begin
                tgt   = PortW'(i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        tgt_gnt    = (tgt == ErrIdx);
        sel_rvalid = 1'b0;
        sel_err    = 1'b0;
        sel_rdata  = '0;
        sel_rid    = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            if (tgt == PortW'(i)) tgt_gnt = mgr_ports_gnt_i[i];
            if (cur_tgt_q == PortW'(i)) begin
                sel_rvalid = mgr_ports_rvalid_i[i] && !hung_q[i];
                sel_err    = mgr_ports_err_i[i];
                sel_rdata  = mgr_ports_rdata_i[i*DataWidth +: DataWidth];
                sel_rid    = mgr_ports_rid_i[i*IdWidth +: IdWidth];
            end
        end
    end

    // Responses only count while a transaction is outstanding; stale ones are dropped.
    assign tgt_rvalid = (state_q == BUSY) && sel_rvalid;

    assign issue_ok = (state_q != FLUSH)
                      && ((cnt_q == '0)
                          || ((tgt == cur_tgt_q) && (cnt_q < CntW'(NumMaxTrans))));

    assign hs  = sbr_port_req_i & sbr_port_gnt_o;
    assign pop = sbr_port_rvalid_o;

    assign flush_entry = (state_q == BUSY) && (cur_tgt_q != ErrIdx)
                         && (wd_q == WdW'(TimeoutCycles - 1)) && !tgt_rvalid && !hs;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (hs) state_d = BUSY;
            BUSY: begin
                if (flush_entry)                              state_d = FLUSH;
                else if ((cnt_q == CntW'(1)) && pop && !hs)  state_d = IDLE;
            end
            FLUSH:   if (cnt_q == CntW'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sbr_port_gnt_o    = 1'b0;
        mgr_ports_req_o   = '0;
        mgr_ports_addr_o  = '0;
        mgr_ports_we_o    = 1'b0;
        mgr_ports_be_o    = '0;
        mgr_ports_wdata_o = '0;
        mgr_ports_aid_o   = '0;
        sbr_port_rvalid_o = 1'b0;
        sbr_port_err_o    = 1'b0;
        sbr_port_rdata_o  = '0;
        sbr_port_rid_o    = '0;

        if (sbr_port_req_i && issue_ok) begin
            sbr_port_gnt_o = tgt_gnt;
            for (int unsigned i = 0; i < NumPorts; i++) begin
                if (tgt == PortW'(i)) mgr_ports_req_o[i] = 1'b1;
            end
        end
        if (mgr_ports_req_o != '0) begin
            mgr_ports_addr_o  = sbr_port_addr_i;
            mgr_ports_we_o    = sbr_port_we_i;
            mgr_ports_be_o    = sbr_port_be_i;
            mgr_ports_wdata_o = sbr_port_wdata_i;
            mgr_ports_aid_o   = sbr_port_aid_i;
        end

        if ((state_q == FLUSH) || err_rsp_q) begin
            sbr_port_rvalid_o = 1'b1;
            sbr_port_err_o    = 1'b1;
            sbr_port_rdata_o  = ErrData;
            sbr_port_rid_o    = fifo_q[rd_ptr_q];
        end else if (tgt_rvalid) begin
            sbr_port_rvalid_o = 1'b1;
            sbr_port_err_o    = sel_err;
            sbr_port_rdata_o  = sel_rdata;
            sbr_port_rid_o    = sel_rid;
        end
    end

    // A clear arriving during a flush is held until the flush has completed.
    assign clr_req     = hung_clear_i | clr_pend_q;
    assign clr_blocked = (state_q == FLUSH) | flush_entry;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            cur_tgt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wd_q       <= '0;
            hung_q     <= '0;
            err_rsp_q  <= 1'b0;
            irq_q      <= 1'b0;
            clr_pend_q <= 1'b0;
            for (int unsigned i = 0; i < NumMaxTrans; i++) fifo_q[i] <= '0;
        end else begin
            if (hs) begin
                fifo_q[wr_ptr_q] <= sbr_port_aid_i;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
                cur_tgt_q        <= tgt;
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);

            if (hs && !pop)      cnt_q <= cnt_q + CntW'(1);
            else if (!hs && pop) cnt_q <= cnt_q - CntW'(1);

            err_rsp_q <= hs && (tgt == ErrIdx);
            irq_q     <= flush_entry;

            // The watchdog measures silence since the last issue or response.
            if ((state_q != BUSY) || (cur_tgt_q == ErrIdx) || tgt_rvalid || hs) wd_q <= '0;
            else if (wd_q != '1)                                               wd_q <= wd_q + WdW'(1);

            if (clr_req && !clr_blocked) begin
                hung_q     <= '0;
                clr_pend_q <= 1'b0;
            end else if (clr_req) begin
                clr_pend_q <= 1'b1;
            end
            if (flush_entry) begin
                for (int unsigned i = 0; i < NumPorts; i++) begin
                    if (cur_tgt_q == PortW'(i)) hung_q[i] <= 1'b1;
                end
            end
        end
    end

    assign hung_o        = hung_q;
    assign timeout_irq_o = irq_q;

endmodule

// File: tb/tb_user_obi_demux_wd.sv
// Self-checking bench for user_obi_demux_wd: directed scenarios plus randomized
// traffic checked against an in-order scoreboard of decoded responses.
module tb_user_obi_demux_wd;

    localparam int unsigned NP  = 4;
    localparam int unsigned TMO = 16;
    localparam logic [31:0] ERRD = 32'hBADCAB1E;
    localparam int ERR_T = NP;

    logic         clk = 1'b0;
    logic         rst_ni;
    logic [255:0] addr_map;
    logic [3:0]   port_en;
    logic         hung_clear;
    logic         req, we;
    logic [31:0]  addr, wdata;
    logic [3:0]   be, aid;
    logic         gnt, rvalid, err;
    logic [31:0]  rdata;
    logic [3:0]   rid;
    logic [3:0]   m_req, m_be, m_aid;
    logic [31:0]  m_addr, m_wdata;
    logic         m_we;
    logic [3:0]   m_gnt, m_rvalid, m_err;
    logic [127:0] m_rdata;
    logic [15:0]  m_rid;
    logic [3:0]   hung;
    logic         irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] map_start [NP] = '{32'h1000, 32'h1800, 32'h3000, 32'h4000};
    logic [31:0] map_end   [NP] = '{32'h2000, 32'h3000, 32'h4000, 32'h5000};

    always #5 clk = ~clk;

    user_obi_demux_wd #(
        .AddrWidth(32), .DataWidth(32), .IdWidth(4),
        .NumPorts(NP), .NumMaxTrans(2), .TimeoutCycles(TMO), .ErrData(ERRD)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .addr_map_i(addr_map), .port_en_i(port_en),
        .hung_clear_i(hung_clear),
        .sbr_port_req_i(req), .sbr_port_addr_i(addr), .sbr_port_we_i(we),
        .sbr_port_be_i(be), .sbr_port_wdata_i(wdata), .sbr_port_aid_i(aid),
        .sbr_port_gnt_o(gnt), .sbr_port_rvalid_o(rvalid), .sbr_port_rdata_o(rdata),
        .sbr_port_err_o(err), .sbr_port_rid_o(rid),
        .mgr_ports_req_o(m_req), .mgr_ports_addr_o(m_addr), .mgr_ports_we_o(m_we),
        .mgr_ports_be_o(m_be), .mgr_ports_wdata_o(m_wdata), .mgr_ports_aid_o(m_aid),
        .mgr_ports_gnt_i(m_gnt), .mgr_ports_rvalid_i(m_rvalid), .mgr_ports_rdata_i(m_rdata),
        .mgr_ports_err_i(m_err), .mgr_ports_rid_i(m_rid),
        .hung_o(hung), .timeout_irq_o(irq)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_rsp();
        m_rvalid = '0;
        m_err    = '0;
        m_rdata  = '0;
        m_rid    = '0;
    endtask

    task automatic drive_rsp(input int port, input logic [31:0] d, input logic [3:0] id);
        clear_rsp();
        m_rvalid[port]         = 1'b1;
        m_rdata[port*32 +: 32] = d;
        m_rid[port*4 +: 4]     = id;
    endtask

    task automatic issue(input logic [31:0] a, input logic [3:0] id);
        req  = 1'b1;
        addr = a;
        aid  = id;
    endtask

    function automatic int ref_decode(input logic [31:0] a, input logic [3:0] en, input logic [3:0] hg);
        for (int i = 0; i < NP; i++)
            if (en[i] && !hg[i] && a >= map_start[i] && a < map_end[i]) return i;
        return ERR_T;
    endfunction

    task automatic test_reset();
        rst_ni = 1'b0; req = 1'b0; addr = '0; we = 1'b0; be = 4'hF; wdata = '0; aid = '0;
        port_en = 4'hF; hung_clear = 1'b0; m_gnt = '0; clear_rsp();
        for (int i = 0; i < NP; i++) begin
            addr_map[i*64+32 +: 32] = map_start[i];
            addr_map[i*64 +: 32]    = map_end[i];
        end
        repeat (3) next_cycle();
        sample();
        checks++;
        if ({gnt, rvalid, err, rdata, rid, m_req, hung, irq} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got gnt=%b rvalid=%b err=%b rdata=%h rid=%h mreq=%b hung=%b irq=%b want all 0",
                     gnt, rvalid, err, rdata, rid, m_req, hung, irq);
        end
        next_cycle();
        rst_ni = 1'b1;
        next_cycle();
    endtask

    task automatic test_single_read();
        m_gnt = 4'hF;
        issue(32'h2800, 4'd3);
        sample();
        checks++;
        if (m_req !== 4'b0010 || gnt !== 1'b1 || m_addr !== 32'h2800) begin
            errors++;
            $display("FAIL single_fwd got mreq=%b gnt=%b maddr=%h want 0010 1 00002800", m_req, gnt, m_addr);
        end
        next_cycle(); req = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            sample();
            checks++;
            if (rvalid !== 1'b0) begin errors++; $display("FAIL single_early_rvalid got %b want 0", rvalid); end
            next_cycle();
        end
        drive_rsp(1, 32'hCAFE0001, 4'd3);
        sample();
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'hCAFE0001 || err !== 1'b0 || rid !== 4'd3 || hung !== 4'b0) begin
            errors++;
            $display("FAIL single_rsp got rvalid=%b rdata=%h err=%b rid=%0d hung=%b want 1 cafe0001 0 3 0000",
                     rvalid, rdata, err, rid, hung);
        end
        next_cycle(); clear_rsp();
    endtask

    task automatic test_err_sink();
        m_gnt = 4'h0;
        issue(32'h9000, 4'd5);
        sample();
        checks++;
        if (gnt !== 1'b1 || m_req !== 4'b0) begin
            errors++; $display("FAIL err_gnt got gnt=%b mreq=%b want 1 0000", gnt, m_req);
        end
        next_cycle(); req = 1'b0;
        sample();
        checks++;
        if (rvalid !== 1'b1 || err !== 1'b1 || rdata !== ERRD || rid !== 4'd5) begin
            errors++;
            $display("FAIL err_rsp got rvalid=%b err=%b rdata=%h rid=%0d want 1 1 badcab1e 5", rvalid, err, rdata, rid);
        end
        next_cycle();
        sample();
        checks++;
        if (rvalid !== 1'b0) begin errors++; $display("FAIL err_rsp_once got rvalid=%b want 0", rvalid); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        m_gnt = 4'hF;
        issue(32'h1100, 4'd1);
        sample();
        checks++;
        if (gnt !== 1'b1 || m_req !== 4'b0001) begin
            errors++; $display("FAIL b2b_first got gnt=%b mreq=%b want 1 0001", gnt, m_req);
        end
        next_cycle(); issue(32'h3100, 4'd2);
        for (int c = 0; c < 2; c++) begin
            sample();
            checks++;
            if (gnt !== 1'b0 || m_req !== 4'b0) begin
                errors++; $display("FAIL b2b_stall got gnt=%b mreq=%b want 0 0000", gnt, m_req);
            end
            next_cycle();
        end
        drive_rsp(0, 32'hD0D0_0000, 4'd1);
        sample();
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'hD0D0_0000 || rid !== 4'd1 || gnt !== 1'b0) begin
            errors++;
            $display("FAIL b2b_rsp0 got rvalid=%b rdata=%h rid=%0d gnt=%b want 1 d0d00000 1 0", rvalid, rdata, rid, gnt);
        end
        next_cycle(); clear_rsp();
        sample();
        checks++;
        if (gnt !== 1'b1 || m_req !== 4'b0100) begin
            errors++; $display("FAIL b2b_second got gnt=%b mreq=%b want 1 0100", gnt, m_req);
        end
        next_cycle(); req = 1'b0;
        next_cycle(); drive_rsp(2, 32'hD2D2_0000, 4'd2);
        sample();
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'hD2D2_0000 || rid !== 4'd2) begin
            errors++; $display("FAIL b2b_rsp2 got rvalid=%b rdata=%h rid=%0d want 1 d2d20000 2", rvalid, rdata, rid);
        end
        next_cycle(); clear_rsp();
    endtask

    task automatic test_port_disable();
        m_gnt = 4'hF; port_en = 4'b1110;
        issue(32'h1100, 4'd3);
        sample();
        checks++;
        if (gnt !== 1'b1 || m_req !== 4'b0) begin
            errors++; $display("FAIL dis_gnt got gnt=%b mreq=%b want 1 0000", gnt, m_req);
        end
        next_cycle(); req = 1'b0;
        sample();
        checks++;
        if (rvalid !== 1'b1 || err !== 1'b1 || rid !== 4'd3 || rdata !== ERRD) begin
            errors++; $display("FAIL dis_rsp got rvalid=%b err=%b rid=%0d rdata=%h want 1 1 3 badcab1e", rvalid, err, rid, rdata);
        end
        next_cycle(); port_en = 4'hF;
        issue(32'h2100, 4'd1);
        sample();
        checks++;
        if (m_req !== 4'b0010 || gnt !== 1'b1) begin
            errors++; $display("FAIL sim_first got mreq=%b gnt=%b want 0010 1", m_req, gnt);
        end
        next_cycle(); issue(32'h2200, 4'd2); drive_rsp(1, 32'h1111_0001, 4'd1);
        sample();
        checks++;
        if (gnt !== 1'b1 || rvalid !== 1'b1 || rid !== 4'd1) begin
            errors++; $display("FAIL sim_both got gnt=%b rvalid=%b rid=%0d want 1 1 1", gnt, rvalid, rid);
        end
        next_cycle(); req = 1'b0; clear_rsp();
        next_cycle(); drive_rsp(1, 32'h1111_0002, 4'd2);
        sample();
        checks++;
        if (rvalid !== 1'b1 || rid !== 4'd2 || rdata !== 32'h1111_0002) begin
            errors++; $display("FAIL sim_second_rsp got rvalid=%b rid=%0d rdata=%h want 1 2 11110002", rvalid, rid, rdata);
        end
        next_cycle(); clear_rsp(); issue(32'h3100, 4'd4);
        sample();
        checks++;
        if (gnt !== 1'b1 || m_req !== 4'b0100) begin
            errors++; $display("FAIL sim_cnt_empty got gnt=%b mreq=%b want 1 0100", gnt, m_req);
        end
        next_cycle(); req = 1'b0;
        next_cycle(); drive_rsp(2, 32'h2222_0004, 4'd4);
        next_cycle(); clear_rsp();
    endtask

    task automatic test_timeout();
        int  waited;
        logic seen;
        m_gnt = 4'hF; clear_rsp();
        issue(32'h4100, 4'd7);
        sample();
        checks++;
        if (gnt !== 1'b1 || m_req !== 4'b1000) begin
            errors++; $display("FAIL tmo_issue0 got gnt=%b mreq=%b want 1 1000", gnt, m_req);
        end
        next_cycle(); issue(32'h4200, 4'd9);
        sample();
        checks++;
        if (gnt !== 1'b1 || m_req !== 4'b1000) begin
            errors++; $display("FAIL tmo_issue1 got gnt=%b mreq=%b want 1 1000", gnt, m_req);
        end
        // The last issue takes effect at the next edge; the pulse follows TMO edges later.
        seen = 1'b0; waited = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            next_cycle(); req = 1'b0;
            sample();
            if (irq === 1'b1) begin seen = 1'b1; waited = k; end
        end
        checks++;
        if (waited != TMO + 1) begin
            errors++; $display("FAIL tmo_irq_time got %0d want %0d", waited, TMO + 1);
        end
        checks++;
        if (rvalid !== 1'b1 || err !== 1'b1 || rid !== 4'd7 || rdata !== ERRD || hung !== 4'b1000) begin
            errors++;
            $display("FAIL tmo_flush0 got rvalid=%b err=%b rid=%0d rdata=%h hung=%b want 1 1 7 badcab1e 1000",
                     rvalid, err, rid, rdata, hung);
        end
        next_cycle(); issue(32'h2400, 4'd1);
        sample();
        checks++;
        if (rvalid !== 1'b1 || err !== 1'b1 || rid !== 4'd9 || irq !== 1'b0 || gnt !== 1'b0 || m_req !== 4'b0) begin
            errors++;
            $display("FAIL tmo_flush1 got rvalid=%b err=%b rid=%0d irq=%b gnt=%b mreq=%b want 1 1 9 0 0 0000",
                     rvalid, err, rid, irq, gnt, m_req);
        end
        next_cycle(); req = 1'b0;
        sample();
        checks++;
        if (rvalid !== 1'b0 || hung !== 4'b1000) begin
            errors++; $display("FAIL tmo_done got rvalid=%b hung=%b want 0 1000", rvalid, hung);
        end
        next_cycle(); issue(32'h4300, 4'd4);
        sample();
        checks++;
        if (gnt !== 1'b1 || m_req !== 4'b0) begin
            errors++; $display("FAIL hung_isolate got gnt=%b mreq=%b want 1 0000", gnt, m_req);
        end
        next_cycle(); req = 1'b0;
        sample();
        checks++;
        if (rvalid !== 1'b1 || err !== 1'b1 || rid !== 4'd4) begin
            errors++; $display("FAIL hung_err_rsp got rvalid=%b err=%b rid=%0d want 1 1 4", rvalid, err, rid);
        end
        next_cycle();
    endtask

    task automatic test_hung_clear();
        hung_clear = 1'b1;
        next_cycle(); hung_clear = 1'b0;
        sample();
        checks++;
        if (hung !== 4'b0) begin errors++; $display("FAIL clr_idle got hung=%b want 0000", hung); end
        next_cycle(); drive_rsp(3, 32'h57A1_E000, 4'd9);
        sample();
        checks++;
        if (rvalid !== 1'b0) begin errors++; $display("FAIL stale_drop got rvalid=%b want 0", rvalid); end
        next_cycle(); clear_rsp(); issue(32'h4400, 4'd6);
        sample();
        checks++;
        if (m_req !== 4'b1000 || gnt !== 1'b1) begin
            errors++; $display("FAIL clr_fwd got mreq=%b gnt=%b want 1000 1", m_req, gnt);
        end
        next_cycle(); req = 1'b0; drive_rsp(3, 32'h3333_0006, 4'd6);
        sample();
        checks++;
        if (rvalid !== 1'b1 || err !== 1'b0 || rid !== 4'd6 || rdata !== 32'h3333_0006) begin
            errors++; $display("FAIL clr_rsp got rvalid=%b err=%b rid=%0d rdata=%h want 1 0 6 33330006", rvalid, err, rid, rdata);
        end
        next_cycle(); clear_rsp();
    endtask

    task automatic test_flush_clear();
        logic seen;
        issue(32'h4500, 4'd2);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (k > 0) begin next_cycle(); req = 1'b0; end
            sample();
            if (irq === 1'b1) begin seen = 1'b1; hung_clear = 1'b1; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL fclr_irq got none want pulse"); end
        next_cycle(); hung_clear = 1'b0;
        sample();
        checks++;
        if (hung !== 4'b1000 || rvalid !== 1'b0) begin
            errors++; $display("FAIL fclr_deferred got hung=%b rvalid=%b want 1000 0", hung, rvalid);
        end
        next_cycle();
        sample();
        checks++;
        if (hung !== 4'b0) begin errors++; $display("FAIL fclr_applied got hung=%b want 0000", hung); end
        next_cycle();
    endtask

    typedef struct { logic [31:0] rdata; logic err; logic [3:0] rid; } exp_t;
    typedef struct { int port; logic [31:0] rdata; logic [3:0] rid; int ready; } ds_t;

    task automatic test_random();
        exp_t exp_q[$];
        ds_t  ds_q[$];
        exp_t e;
        ds_t  d;
        logic [31:0] picks [12] = '{32'h0FFF, 32'h1000, 32'h17FF, 32'h1800, 32'h1FFF, 32'h2000,
                                    32'h2FFF, 32'h3000, 32'h3FFF, 32'h4000, 32'h4FFF, 32'h5000};
        int   issued = 0, cyc = 0, t;
        logic active = 1'b0, drove;
        logic [3:0] onehot;
        req = 1'b0;
        while ((issued < 150 || exp_q.size() != 0) && cyc < 3000) begin
            next_cycle();
            cyc++;
            if (!active) req = 1'b0;
            if (cyc % 64 == 0) port_en = 4'($urandom_range(0, 15));
            if (!active && issued < 150 && $urandom_range(0, 3) != 0) begin
                t = int'($urandom_range(0, 15));
                issue((t < 12) ? picks[t] : 32'($urandom_range(0, 32'h5FFF)), 4'($urandom_range(0, 15)));
                active = 1'b1;
            end
            m_gnt = 4'($urandom_range(0, 15));
            clear_rsp();
            drove = 1'b0;
            if (ds_q.size() != 0 && cyc >= ds_q[0].ready) begin
                drive_rsp(ds_q[0].port, ds_q[0].rdata, ds_q[0].rid);
                drove = 1'b1;
            end
            sample();
            if (drove) void'(ds_q.pop_front());
            if (rvalid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd_unexpected_rsp got rid=%0d want none", rid);
                end else begin
                    e = exp_q.pop_front();
                    if (rdata !== e.rdata || err !== e.err || rid !== e.rid) begin
                        errors++;
                        $display("FAIL rnd_rsp got rdata=%h err=%b rid=%0d want %h %b %0d", rdata, err, rid, e.rdata, e.err, e.rid);
                    end
                end
            end
            if (req) begin
                t = ref_decode(addr, port_en, 4'b0);
                onehot = (t == ERR_T) ? 4'b0 : 4'(1 << t);
                checks++;
                if (m_req !== 4'b0 && m_req !== onehot) begin
                    errors++; $display("FAIL rnd_route addr=%h got mreq=%b want %b", addr, m_req, onehot);
                end
                if (gnt === 1'b1) begin
                    issued++;
                    active = 1'b0;
                    if (t == ERR_T) begin
                        e.rdata = ERRD; e.err = 1'b1; e.rid = aid;
                    end else begin
                        e.rdata = addr ^ 32'h5A5A_0000; e.err = 1'b0; e.rid = aid;
                        d.port = t; d.rdata = e.rdata; d.rid = aid;
                        d.ready = cyc + int'($urandom_range(1, 4));
                        ds_q.push_back(d);
                    end
                    exp_q.push_back(e);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0 || issued != 150) begin
            errors++; $display("FAIL rnd_drain got pending=%0d issued=%0d want 0 150", exp_q.size(), issued);
        end
        checks++;
        if (hung !== 4'b0) begin errors++; $display("FAIL rnd_hung got %b want 0000", hung); end
        next_cycle(); req = 1'b0; clear_rsp(); port_en = 4'hF;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        m_gnt = 4'hF;
        issue(32'h2500, 4'd1);
        next_cycle(); req = 1'b0; rst_ni = 1'b0;
        sample();
        checks++;
        if (rvalid !== 1'b0 || m_req !== 4'b0 || hung !== 4'b0 || irq !== 1'b0) begin
            errors++; $display("FAIL rst_mid got rvalid=%b mreq=%b hung=%b irq=%b want 0", rvalid, m_req, hung, irq);
        end
        next_cycle(); rst_ni = 1'b1; drive_rsp(1, 32'hDEAD_0001, 4'd1);
        sample();
        checks++;
        if (rvalid !== 1'b0) begin errors++; $display("FAIL rst_no_rsp got rvalid=%b want 0", rvalid); end
        next_cycle(); clear_rsp();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_err_sink();
        test_back_to_back();
        test_port_disable();
        test_timeout();
        test_hung_clear();
        test_flush_clear();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
